// File: rtl/serial_add_sub_pkg.sv
// Shared constants and FSM state type for the digit-serial adder/subtractor.
package serial_add_sub_pkg;

    localparam int OP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_sub_digit_adder.sv
// Combinational W-bit ripple-carry adder for one digit slice.
// Also exposes the carry into the MSB so the top level can derive signed overflow.
module digit_adder
    import serial_add_sub_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         carry_msb
);

    logic [W:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout      = carry[W];
    assign carry_msb = carry[W-1];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial 32-bit add/subtract, DIGIT_W bits per cycle, LSB digit first.
// Subtraction is built only when SERIAL_ADD_SUB_SUB_EN is defined; otherwise sub is ignored.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic            cin,
    input  logic            sub,
    output logic            busy,
    output logic            done,
    output logic [OP_W-1:0] sum,
    output logic            cout,
    output logic            of
);

    localparam int N     = OP_W / DIGIT_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t state, state_next;

    logic [OP_W-1:0]    a_sh;
    logic [OP_W-1:0]    b_sh;
    logic [OP_W-1:0]    res_sh;
    logic [OP_W-1:0]    res_next;
    logic [CNT_W-1:0]   cnt;
    logic               carry_q;
    logic [DIGIT_W-1:0] digit_sum;
    logic               digit_cout;
    logic               digit_cmsb;
    logic               accept;
    logic               last_digit;
    logic [OP_W-1:0]    b_load;
    logic               carry_load;

    // A new operation may be accepted from IDLE or from FIN (back-to-back).
    assign accept     = start && (state != RUN);
    assign last_digit = (cnt == CNT_W'(N - 1));

`ifdef SERIAL_ADD_SUB_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = b;
    assign carry_load = cin;
`endif

    digit_adder #(
        .W(DIGIT_W)
    ) u_digit_adder (
        .a        (a_sh[DIGIT_W-1:0]),
        .b        (b_sh[DIGIT_W-1:0]),
        .cin      (carry_q),
        .sum      (digit_sum),
        .cout     (digit_cout),
        .carry_msb(digit_cmsb)
    );

    // New digits enter at the top so the first (LSB) digit ends at bit 0 after N shifts.
    assign res_next = OP_W'({digit_sum, res_sh} >> DIGIT_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            of      <= 1'b0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b_load;
            res_sh  <= '0;
            cnt     <= '0;
            carry_q <= carry_load;
        end else if (state == RUN) begin
            a_sh    <= a_sh >> DIGIT_W;
            b_sh    <= b_sh >> DIGIT_W;
            res_sh  <= res_next;
            cnt     <= cnt + CNT_W'(1);
            carry_q <= digit_cout;
            // Results are published only as the final digit completes.
            if (last_digit) begin
                sum  <= res_next;
                cout <= digit_cout;
                of   <= digit_cmsb ^ digit_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench: directed cases on a DIGIT_W=4 instance plus random sweeps at DIGIT_W 1, 8 and 32.
// Honours SERIAL_ADD_SUB_SUB_EN in its reference model and directed expectations.
module tb_serial_add_sub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;
    logic        of;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_add_sub #(
        .DIGIT_W(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sub  (sub),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .of   (of)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Plain 33-bit arithmetic: returns {of, cout, sum}.
    function automatic logic [33:0] refModel(input logic [31:0] ra, input logic [31:0] rb,
                                             input logic rc, input logic rs);
        logic        sub_eff;
        logic [31:0] bo;
        logic        c0;
        logic [32:0] full;
        logic        ovf;
`ifdef SERIAL_ADD_SUB_SUB_EN
        sub_eff = rs;
`else
        sub_eff = rs & 1'b0;
`endif
        bo   = sub_eff ? ~rb : rb;
        c0   = sub_eff ? 1'b1 : rc;
        full = {1'b0, ra} + {1'b0, bo} + {32'd0, c0};
        ovf  = (ra[31] == bo[31]) && (full[31] != ra[31]);
        return {ovf, full[32], full[31:0]};
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where done is seen, latency in edges.
    task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input logic tci,
                                 input logic tsb, output int lat);
        lat   = -1;
        a     = ta;
        b     = tb;
        cin   = tci;
        sub   = tsb;
        start = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_sweep
            localparam int W  = (g == 0) ? 1 : (g == 1) ? 8 : 32;
            localparam int NN = 32 / W;
            logic        rn, st, ci, sb, bz, dn, co, ov;
            logic [31:0] aa, bb, sm;
            logic        fin_flag = 1'b0;

            serial_add_sub #(
                .DIGIT_W(W)
            ) u_dut (
                .clk  (clk),
                .rst_n(rn),
                .start(st),
                .a    (aa),
                .b    (bb),
                .cin  (ci),
                .sub  (sb),
                .busy (bz),
                .done (dn),
                .sum  (sm),
                .cout (co),
                .of   (ov)
            );

            initial begin
                int          lat;
                logic [31:0] ra, rb;
                logic        rc, rs;
                logic [33:0] e;
                rn = 1'b0; st = 1'b0; aa = '0; bb = '0; ci = 1'b0; sb = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rn = 1'b1;
                for (int op = 0; op < 1000; op++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        st = 1'b0;
                        @(negedge clk);
                    end
                    ra = pickOperand();
                    rb = pickOperand();
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'($urandom_range(0, 1));
                    e  = refModel(ra, rb, rc, rs);
                    aa = ra; bb = rb; ci = rc; sb = rs; st = 1'b1;
                    lat = -1;
                    for (int c = 1; c <= 100; c++) begin
                        @(negedge clk);
                        if (dn) begin
                            lat = c;
                            break;
                        end
                        // Requests while busy must be dropped; operands here are junk.
                        st = ($urandom_range(0, 3) == 0);
                        aa = $urandom;
                        bb = $urandom;
                        ci = 1'($urandom_range(0, 1));
                        sb = 1'($urandom_range(0, 1));
                    end
                    checkOutput($sformatf("w%0d_latency", W), 64'(lat), 64'(NN + 1));
                    if (lat < 0) break;
                    checkOutput($sformatf("w%0d_result op%0d", W, op), {30'd0, ov, co, sm}, {30'd0, e});
                end
                st = 1'b0;
                fin_flag = 1'b1;
            end
        end
    endgenerate

    initial begin
        int lat;
        int done_cnt;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_sum",  sum,  0);
        checkOutput("reset_cout", cout, 0);
        checkOutput("reset_of",   of,   0);

        // Start coincides with reset release so the first rising edge must accept it.
        rst_n = 1'b1;
        applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, lat);
        checkOutput("max_pos_latency", 64'(lat), 9);
        checkOutput("max_pos_sum",  sum,  32'hFFFF_FFFE);
        checkOutput("max_pos_cout", cout, 0);
        checkOutput("max_pos_of",   of,   1);
        checkOutput("busy_in_fin",  busy, 0);
        @(negedge clk);
        checkOutput("done_pulse_width", done, 0);

        applyStimulus(32'h8FFF_FFFF, 32'h8FFF_FFFF, 1'b0, 1'b0, lat);
        checkOutput("neg_ovf_sum",  sum,  32'h1FFF_FFFE);
        checkOutput("neg_ovf_cout", cout, 1);
        checkOutput("neg_ovf_of",   of,   1);
        @(negedge clk);
        checkOutput("sum_held_idle", sum, 32'h1FFF_FFFE);

        applyStimulus(32'h0000_00AF, 32'h0000_00AF, 1'b1, 1'b0, lat);
        checkOutput("cin_sum",  sum,  32'h0000_015F);
        checkOutput("cin_cout", cout, 0);
        checkOutput("cin_of",   of,   0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
        checkOutput("b2b_latency", 64'(lat), 9);
        checkOutput("b2b_sum",  sum,  32'hFFFF_FFFE);
        checkOutput("b2b_cout", cout, 1);
        checkOutput("b2b_of",   of,   0);
        @(negedge clk);

        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, lat);
`ifdef SERIAL_ADD_SUB_SUB_EN
        checkOutput("sub_sum",  sum,  32'h7FFF_FFFF);
        checkOutput("sub_cout", cout, 1);
        checkOutput("sub_of",   of,   1);
`else
        checkOutput("sub_sum",  sum,  32'h8000_0002);
        checkOutput("sub_cout", cout, 0);
        checkOutput("sub_of",   of,   0);
`endif
        @(negedge clk);

        // Abort: second start mid-run is ignored, then reset mid-run.
        a = 32'h1234_5678; b = 32'h0F0F_0F0F; cin = 1'b0; sub = 1'b0; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = (k == 3);
            if (k == 3) begin
                a = 32'hDEAD_BEEF;
                b = 32'h0BAD_F00D;
            end
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_sum",  sum,  0);
        checkOutput("abort_cout", cout, 0);
        checkOutput("abort_of",   of,   0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checkOutput("abort_no_done", 64'(done_cnt), 0);
        applyStimulus(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
        checkOutput("post_abort_latency", 64'(lat), 9);
        checkOutput("post_abort_sum",  sum,  32'hFFFF_FFFF);
        checkOutput("post_abort_cout", cout, 0);
        checkOutput("post_abort_of",   of,   0);

        for (int c = 0; c < 60000; c++) begin
            if (g_sweep[0].fin_flag && g_sweep[1].fin_flag && g_sweep[2].fin_flag) break;
            @(negedge clk);
        end
        checkOutput("sweep_complete",
                    {61'd0, g_sweep[0].fin_flag, g_sweep[1].fin_flag, g_sweep[2].fin_flag}, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 The block SHALL have parameter DIGIT_W, default 4, giving the operand bits processed per cycle; legal values are 1, 2, 4, 8, 16 and 32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, an operation request; it is sampled only when the block is not busy.
REQ-005 The block SHALL have port a, input, 32 bits, operand A in two's complement, captured at an accepted start.
REQ-006 The block SHALL have port b, input, 32 bits, operand B in two's complement, captured at an accepted start.
REQ-007 The block SHALL have port cin, input, 1 bit, the carry-in for add, captured at an accepted start.
REQ-008 The block SHALL have port sub, input, 1 bit, the operation select (0 = add, 1 = subtract), captured at an accepted start.
REQ-009 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse when a result is valid.
REQ-011 The block SHALL have port sum, output, 32 bits, the result.
REQ-012 The block SHALL have port cout, output, 1 bit, the carry out of bit 31.
REQ-013 The block SHALL have port of, output, 1 bit, signed overflow.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and FIN. IDLE goes to RUN on start. RUN goes to FIN after N = 32/DIGIT_W digit cycles. FIN goes to RUN if start is high, otherwise to IDLE.
REQ-015 In RUN, each cycle SHALL add one DIGIT_W slice, LSB slice first, and register the carry into the next cycle.
REQ-016 The initial carry SHALL be cin for add; for subtract, B SHALL be inverted and the initial carry forced to 1, with cin ignored.
REQ-017 busy SHALL be high exactly in RUN; done SHALL be high exactly in FIN. Latency from the start sample to done is N+1 cycles.
REQ-018 sum, cout and of SHALL update only on entry to FIN and hold until the next entry to FIN.
REQ-019 cout SHALL be the carry out of bit 31; for subtract, cout = 1 means no borrow.
REQ-020 of SHALL equal the carry into bit 31 XOR the carry out of bit 31.
REQ-021 start while busy SHALL be ignored, with no queuing; start in the FIN cycle SHALL be accepted, giving back-to-back operation.
REQ-022 Operand inputs SHALL be don't-care except at the accepted start cycle.

Reset
REQ-023 On rst_n low, the block SHALL asynchronously enter IDLE with busy = 0, done = 0, sum = 0, cout = 0, of = 0, and all internal registers cleared.
REQ-024 Reset asserted mid-RUN SHALL abandon the operation; no done pulse follows the deassertion.
REQ-025 The first start SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-026 The macro SERIAL_ADD_SUB_SUB_EN SHALL control subtraction. When defined, the sub input is honoured per REQ-016. When undefined, the sub port exists but is ignored, every operation is an add, and the inversion logic is absent.

Structure
REQ-027 Package serial_add_sub_pkg SHALL hold the operand width constant (32) and the FSM state enum (IDLE, RUN, FIN).
REQ-028 Sub-module digit_adder SHALL be a combinational DIGIT_W-bit ripple adder with carry in, carry out and carry into its MSB; it is instantiated once.
REQ-029 The RTL SHALL use operand shift registers, a log2(N)-bit digit counter and a carry register.

Verification
REQ-030 Add A = 0x7FFFFFFF, B = 0x7FFFFFFF, cin = 0 -> sum = 0xFFFFFFFE, cout = 0, of = 1, with done exactly 9 cycles after start (DIGIT_W = 4).
REQ-031 Add A = 0x8FFFFFFF, B = 0x8FFFFFFF, cin = 0 -> sum = 0x1FFFFFFE, cout = 1, of = 1.
REQ-032 Add A = 0xAF, B = 0xAF, cin = 1 -> sum = 0x0000015F, cout = 0, of = 0; then start held high in the FIN cycle with A = 0xFFFFFFFF, B = 0xFFFFFFFF, cin = 0 -> sum = 0xFFFFFFFE, cout = 1, of = 0 on the next done.
REQ-033 Subtract (macro defined) A = 0x80000000, B = 0x1, cin = 1 -> sum = 0x7FFFFFFF, cout = 1, of = 1; without the macro, the same stimulus -> sum = 0x80000002, cout = 0, of = 0.
REQ-034 Start an add, pulse start again at RUN cycle 3 (ignored), then assert rst_n low at RUN cycle 5 -> all outputs read 0, no done pulse occurs, and a subsequent add 0x0 + 0xFFFFFFFF gives sum = 0xFFFFFFFF, cout = 0, of = 0.
REQ-035 Sweep DIGIT_W over 1, 8 and 32 with 1000 random operations each -> results match a reference model and latency equals 32/DIGIT_W + 1 cycles.
